// File: rtl/p_pulse_monitor.sv
// p_pulse_monitor: measures cycles between rising edges of p and queues them on a valid/ready port
module p_pulse_monitor #(
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 4,
  parameter int EDGE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p,
  input  logic              clear,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [EDGE_W-1:0] edge_count,
  output logic              overflow,
  output logic              armed
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t            state;
  logic              p_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     rd, wr, rd_n;
  logic [AW:0]       count, left;
  logic              rise, pop, push, full;
  assign rise = p && !p_d;
  assign pop  = out_valid && out_ready;
  assign full = count == (AW+1)'(DEPTH);
  assign push = rise && state == MEASURE && (!full || pop);
  assign rd_n = rd + AW'(pop);
  assign left = count - (AW+1)'(pop);
  // out_valid/out_data only see entries present before this edge, so a push shows up one edge later
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      p_d        <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      rd         <= '0;
      wr         <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      edge_count <= '0;
      overflow   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      p_d <= p;
      if (rise) edge_count <= edge_count + EDGE_W'(1);
      if (rise && state == MEASURE && full && !pop) overflow <= 1'b1;
      if (rise) begin
        state <= MEASURE;
        armed <= 1'b1;
        cnt   <= CNT_W'(1);
      end else if (state == MEASURE && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (push) begin
        mem[wr] <= cnt;
        wr      <= wr + AW'(1);
      end
      rd        <= rd_n;
      count     <= left + (AW+1)'(push);
      out_valid <= left != '0;
      if (left != '0) out_data <= mem[rd_n];
    end
  end
endmodule

// File: tb/tb_p_pulse_monitor.sv
// tb_p_pulse_monitor: directed and random stimulus against a queue-based interval model
module tb_p_pulse_monitor;
  localparam int CW = 5, D = 4, EW = 16;
  localparam int MAXI = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, p = 1'b0, out_ready = 1'b0;
  logic out_valid, overflow, armed;
  logic [CW-1:0] out_data;
  logic [EW-1:0] edge_count;
  int vectors = 0, miscompares = 0, pops_seen = 0;
  int q_val[$], q_ts[$];
  int e = 0, m_last = 0, m_ec = 0, m_od = 0;
  bit m_pd = 0, m_armed = 0, m_ovf = 0;

  always #5 clk = ~clk;

  p_pulse_monitor #(.CNT_W(CW), .DEPTH(D), .EDGE_W(EW)) dut (
    .clk(clk), .reset(reset), .p(p), .clear(clear), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .edge_count(edge_count),
    .overflow(overflow), .armed(armed)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, got, exp, $time);
    end
  endtask

  function automatic bit m_visible(input int done);
    return q_val.size() > 0 && q_ts[0] < done;
  endfunction

  // an entry stamped at edge k is observable once edge k+1 has happened
  task automatic model_edge();
    bit pop, rise;
    int iv;
    e++;
    if (reset || clear) begin
      q_val.delete(); q_ts.delete();
      m_pd = 0; m_armed = 0; m_ovf = 0; m_ec = 0; m_od = 0;
      return;
    end
    pop = m_visible(e - 1) && out_ready;
    rise = p && !m_pd;
    m_pd = p;
    if (pop) begin
      void'(q_val.pop_front());
      void'(q_ts.pop_front());
    end
    if (rise) begin
      m_ec = (m_ec + 1) % (1 << EW);
      if (m_armed) begin
        iv = e - m_last;
        if (iv > MAXI) iv = MAXI;
        if (q_val.size() < D) begin
          q_val.push_back(iv);
          q_ts.push_back(e);
        end else m_ovf = 1;
      end
      m_armed = 1;
      m_last = e;
    end
    if (m_visible(e)) m_od = q_val[0];
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(m_visible(e)));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("edge_count", 32'(edge_count), 32'(m_ec));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("armed", 32'(armed), 32'(m_armed));
  endtask

  task automatic tick(input logic pv, input logic rv);
    p = pv;
    out_ready = rv;
    #1;
    if (out_valid && out_ready && !reset && !clear) pops_seen++;
    @(posedge clk);
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int len;
    logic pv;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_edge_count", 32'(edge_count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    // period-2 toggling: first rise arms, remaining four push 2
    pops_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("p2_edges", 32'(edge_count), 5);
    chk("p2_pops", 32'(pops_seen), 4);
    chk("p2_data", 32'(out_data), 2);
    chk("p2_armed", 32'(armed), 1);
    chk("p2_overflow", 32'(overflow), 0);
    // held high: one rise only
    do_reset();
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b1);
    chk("hold_edges", 32'(edge_count), 1);
    chk("hold_valid", 32'(out_valid), 0);
    // long low stretch saturates the interval
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("sat_data", 32'(out_data), MAXI);
    chk("sat_valid", 32'(out_valid), 1);
    // fill with no consumer, then drain
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_data", 32'(out_data), 3);
    pops_seen = 0;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
    chk("ovf_pops", 32'(pops_seen), 4);
    chk("ovf_drained", 32'(out_valid), 0);
    // full FIFO, pop and push in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end
    pops_seen = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    chk("fullpp_overflow", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
    chk("fullpp_pops", 32'(pops_seen), 5);
    // reset mid-run discards queue and measurement
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      for (int j = 0; j < 3; j++) tick(1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    do_reset();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_edges", 32'(edge_count), 0);
    chk("mid_armed", 32'(armed), 0);
    chk("mid_overflow", 32'(overflow), 0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("mid_data", 32'(out_data), 5);
    chk("mid_valid2", 32'(out_valid), 1);
    // random segments of p with random consumer, occasional clear/reset
    pv = 1'b0;
    for (int s = 0; s < 600; s++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 5);
      pv = ~pv;
      for (int i = 0; i < len; i++) begin
        clear = ($urandom_range(0, 199) == 0);
        reset = ($urandom_range(0, 399) == 0);
        tick(pv, 1'($urandom_range(0, 3) == 0));
      end
    end
    clear = 1'b0;
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
